// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine: FSM encoding, width
// derivations and the row-major index helper.
package matmul_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   // Address width for a DIM x DIM matrix, never narrower than one bit.
   function automatic int addr_w(input int dim);
      int sz;
      sz = dim * dim;
      return ($clog2(sz) < 1) ? 1 : $clog2(sz);
   endfunction

   // Two guard bits beyond the widest sum keep the accumulator overflow-free.
   function automatic int acc_w(input int in_w, input int out_w, input int dim);
      int p;
      p = 2 * in_w + $clog2(dim);
      return ((p > out_w) ? p : out_w) + 2;
   endfunction

   function automatic int row_major(input int i, input int j, input int dim);
      return i * dim + j;
   endfunction

endpackage

// File: rtl/matmul_if.sv
// Host-side RAM access, control handshake and status of the matrix engine.
interface matmul_if
   import matmul_pkg::*;
#(
   parameter int DIM   = 4,
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
);
   localparam int AW = addr_w(DIM);

   logic                    load_mem;
   logic                    wenA, wenB, wenC;
   logic [AW-1:0]           addrA, addrB, addrC;
   logic signed [IN_W-1:0]  wdA, wdB;
   logic signed [OUT_W-1:0] wdC;
   logic                    start, acc_mode, transB, sat_en;
   logic                    busy, done, ovf;
   logic signed [OUT_W-1:0] rdC;

   modport slave (
      input  load_mem, wenA, wenB, wenC, addrA, addrB, addrC, wdA, wdB, wdC,
      input  start, acc_mode, transB, sat_en,
      output busy, done, ovf, rdC
   );

   modport master (
      output load_mem, wenA, wenB, wenC, addrA, addrB, addrC, wdA, wdB, wdC,
      output start, acc_mode, transB, sat_en,
      input  busy, done, ovf, rdC
   );
endinterface

// File: rtl/matmul_mac_sat.sv
// Signed multiply-accumulate with first-term initialisation and an OUT_W
// saturating/wrapping formatter that also reports out-of-range results.
module matmul_mac_sat
   import matmul_pkg::*;
#(
   parameter int DIM   = 4,
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid,
   input  logic                    first,
   input  logic                    acc_mode,
   input  logic                    sat_en,
   input  logic signed [IN_W-1:0]  a,
   input  logic signed [IN_W-1:0]  b,
   input  logic signed [OUT_W-1:0] c_old,
   output logic signed [OUT_W-1:0] result,
   output logic                    ovf
);
   localparam int ACC_W = acc_w(IN_W, OUT_W, DIM);
   localparam int PW    = 2 * IN_W;

   logic signed [PW-1:0]    a_ext, b_ext, prod;
   logic signed [ACC_W-1:0] prod_ext, c_ext, base, acc_reg;
   logic [ACC_W-OUT_W:0]    hi_bits;

   assign a_ext    = {{IN_W{a[IN_W-1]}}, a};
   assign b_ext    = {{IN_W{b[IN_W-1]}}, b};
   assign prod     = a_ext * b_ext;
   assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
   assign c_ext    = {{(ACC_W-OUT_W){c_old[OUT_W-1]}}, c_old};

   always_comb begin
      base = acc_reg;
      if (first) begin
         base = acc_mode ? c_ext : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg <= '0;
      end else if (valid) begin
         acc_reg <= base + prod_ext;
      end
   end

   // In range exactly when every bit from the OUT_W sign bit upward agrees.
   assign hi_bits = acc_reg[ACC_W-1:OUT_W-1];
   assign ovf     = !((&hi_bits) || !(|hi_bits));

   always_comb begin
      result = acc_reg[OUT_W-1:0];
      if (ovf && sat_en) begin
         result = acc_reg[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
endmodule

// File: rtl/matmul_engine.sv
// DIM x DIM signed matrix multiplier over three internal RAMs, one output
// element per DIM+2 cycles, with accumulate, transposed-B and saturation modes.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter int DIM   = 4,
   parameter int IN_W  = 8,
   parameter int OUT_W = 20
) (
   input logic      clk,
   input logic      reset,
   matmul_if.slave  bus
);
   localparam int AW    = addr_w(DIM);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW-1:0] LAST = AW'(DIM - 1);

   state_t state_reg, state_next;
   logic [AW-1:0] i_reg, j_reg, k_reg;
   logic acc_mode_reg, trans_b_reg, sat_en_reg, ovf_reg;
   logic valid_reg, first_reg;
   logic busy, start_ok, last_elem;

   logic [AW-1:0] eng_addr_a, eng_addr_b, elem_addr;
   logic [AW-1:0] addr_a, addr_b, addr_c;
   logic we_a, we_b, we_c;
   logic signed [OUT_W-1:0] wd_c, fmt_val;
   logic fmt_ovf;

   logic signed [IN_W-1:0]  mem_a [DEPTH];
   logic signed [IN_W-1:0]  mem_b [DEPTH];
   logic signed [OUT_W-1:0] mem_c [DEPTH];
   logic signed [IN_W-1:0]  rd_a_reg, rd_b_reg;
   logic signed [OUT_W-1:0] rd_c_reg;

   assign start_ok  = bus.start && !bus.load_mem;
   assign last_elem = (i_reg == LAST) && (j_reg == LAST);

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_ok) state_next = S_ISSUE;
         S_ISSUE: if (k_reg == LAST) state_next = S_DRAIN;
         S_DRAIN: state_next = S_WRITE;
         S_WRITE: state_next = last_elem ? S_DONE : S_ISSUE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_reg == S_ISSUE) || (state_reg == S_DRAIN) || (state_reg == S_WRITE);
      bus.done   = (state_reg == S_DONE);
      eng_addr_a = AW'(row_major(int'(i_reg), int'(k_reg), DIM));
      eng_addr_b = trans_b_reg ? AW'(row_major(int'(j_reg), int'(k_reg), DIM))
                               : AW'(row_major(int'(k_reg), int'(j_reg), DIM));
      elem_addr  = AW'(row_major(int'(i_reg), int'(j_reg), DIM));
   end

   // The engine owns every RAM port for the whole pass; the host only while idle.
   always_comb begin
      addr_a = busy ? eng_addr_a : bus.addrA;
      addr_b = busy ? eng_addr_b : bus.addrB;
      addr_c = busy ? elem_addr  : bus.addrC;
      we_a   = !busy && bus.load_mem && bus.wenA;
      we_b   = !busy && bus.load_mem && bus.wenB;
      we_c   = busy ? (state_reg == S_WRITE) : (bus.load_mem && bus.wenC);
      wd_c   = busy ? fmt_val : bus.wdC;
   end

   always_ff @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= bus.wdA;
      if (we_b) mem_b[addr_b] <= bus.wdB;
      if (we_c) mem_c[addr_c] <= wd_c;
      rd_a_reg <= mem_a[addr_a];
      rd_b_reg <= mem_b[addr_b];
      rd_c_reg <= mem_c[addr_c];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         i_reg <= '0; j_reg <= '0; k_reg <= '0;
         acc_mode_reg <= 1'b0; trans_b_reg <= 1'b0; sat_en_reg <= 1'b0;
         ovf_reg <= 1'b0; valid_reg <= 1'b0; first_reg <= 1'b0;
      end else begin
         valid_reg <= (state_reg == S_ISSUE);
         first_reg <= (state_reg == S_ISSUE) && (k_reg == '0);
         case (state_reg)
            S_IDLE: if (start_ok) begin
               acc_mode_reg <= bus.acc_mode;
               trans_b_reg  <= bus.transB;
               sat_en_reg   <= bus.sat_en;
               ovf_reg      <= 1'b0;
               i_reg <= '0; j_reg <= '0; k_reg <= '0;
            end
            S_ISSUE: k_reg <= (k_reg == LAST) ? '0 : k_reg + AW'(1);
            S_WRITE: begin
               ovf_reg <= ovf_reg | fmt_ovf;
               if (!last_elem) begin
                  j_reg <= (j_reg == LAST) ? '0 : j_reg + AW'(1);
                  if (j_reg == LAST) i_reg <= i_reg + AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   matmul_mac_sat #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W)) u_mac (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid_reg),
      .first    (first_reg),
      .acc_mode (acc_mode_reg),
      .sat_en   (sat_en_reg),
      .a        (rd_a_reg),
      .b        (rd_b_reg),
      .c_old    (rd_c_reg),
      .result   (fmt_val),
      .ovf      (fmt_ovf)
   );

   assign bus.busy = busy;
   assign bus.ovf  = ovf_reg;
   assign bus.rdC  = rd_c_reg;
endmodule

// File: tb/tb_matmul_engine.sv
// Table-driven bench for matmul_engine: each vector loads A/B/C, runs a pass
// and reads C back against a scoreboard of reference products.
module tb_matmul_engine;
   import matmul_pkg::*;

   localparam int DIM      = 4;
   localparam int IN_W     = 8;
   localparam int OUT_W    = 16;
   localparam int N        = DIM * DIM;
   localparam int AW       = addr_w(DIM);
   localparam int PASS_CYC = N * (DIM + 2);

   typedef struct {
      int a_kind;
      int b_kind;
      bit acc;
      bit tr;
      bit sat;
      int c_pre;
      bit exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matmul_if #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   matmul_engine #(.DIM(DIM), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t vecs[7];
   int   ma[N];
   int   mb[N];
   int   exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string what, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", what, act, exp);
      end
   endtask

   // kinds: 0 identity, 1 row-major index, 2 const 2, 3 const 3,
   //        4 small random, 5 const -128, 6 const 127
   function automatic int elem(input int kind, input int r, input int c);
      case (kind)
         0:       return (r == c) ? 1 : 0;
         1:       return r * DIM + c;
         2:       return 2;
         3:       return 3;
         4:       return int'($urandom_range(40, 0)) - 20;
         5:       return -128;
         default: return 127;
      endcase
   endfunction

   function automatic int fmt_model(input int acc, input bit sat);
      int maxv, minv, lo;
      maxv = (1 << (OUT_W - 1)) - 1;
      minv = -(1 << (OUT_W - 1));
      if (sat) return (acc > maxv) ? maxv : ((acc < minv) ? minv : acc);
      lo = acc & ((1 << OUT_W) - 1);
      if (lo > maxv) lo -= (1 << OUT_W);
      return lo;
   endfunction

   task automatic load(input vec_t v);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ma[r*DIM+c] = elem(v.a_kind, r, c);
            mb[r*DIM+c] = elem(v.b_kind, r, c);
         end
      bus.load_mem = 1'b1;
      bus.wenA = 1'b1; bus.wenB = 1'b1; bus.wenC = 1'b1;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            bus.addrA = AW'(r*DIM+c);
            bus.wdA   = IN_W'(ma[r*DIM+c]);
            bus.addrB = AW'(r*DIM+c);
            bus.wdB   = v.tr ? IN_W'(mb[c*DIM+r]) : IN_W'(mb[r*DIM+c]);
            bus.addrC = AW'(r*DIM+c);
            bus.wdC   = OUT_W'(v.c_pre);
            @(posedge clk); #1;
         end
      bus.wenA = 1'b0; bus.wenB = 1'b0; bus.wenC = 1'b0;
      bus.load_mem = 1'b0;
   endtask

   task automatic push_expected(input vec_t v);
      int acc;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            acc = v.acc ? v.c_pre : 0;
            for (int k = 0; k < DIM; k++) acc += ma[i*DIM+k] * mb[k*DIM+j];
            exp_q.push_back(fmt_model(acc, v.sat));
         end
   endtask

   // mode 0: plain pass; 1: start and host writes injected mid-pass; 2: reset at cycle 40
   task automatic run_pass(input vec_t v, input int mode);
      int done_cyc, busy_cnt;
      done_cyc = -1;
      busy_cnt = 0;
      bus.acc_mode = v.acc; bus.transB = v.tr; bus.sat_en = v.sat;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= PASS_CYC + 20; c++) begin
         if (mode == 2 && c == 41) begin
            check("rst_busy", int'(bus.busy), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_ovf", int'(bus.ovf), 0);
            reset = 1'b0;
            $display("[TB] pass aborted by reset at cycle 40");
            return;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cyc = c;
            break;
         end
         if (mode == 1) begin
            case (c)
               10: bus.start = 1'b1;
               11: bus.start = 1'b0;
               20: begin bus.load_mem = 1'b1; bus.wenA = 1'b1; bus.addrA = '0; bus.wdA = 8'sd55; end
               23: begin bus.load_mem = 1'b0; bus.wenA = 1'b0; end
               default: ;
            endcase
         end
         if (mode == 2 && c == 40) begin
            check("ovf_before_rst", int'(bus.ovf), int'(v.exp_ovf));
            reset = 1'b1;
         end
         @(posedge clk); #1;
      end
      check("done_cycle", done_cyc, PASS_CYC + 1);
      check("busy_cycles", busy_cnt, PASS_CYC);
      check("ovf", int'(bus.ovf), int'(v.exp_ovf));
      $display("[TB] pass mode=%0d acc=%0d transB=%0d sat=%0d done_cycle=%0d ovf=%0d",
               mode, v.acc, v.tr, v.sat, done_cyc, bus.ovf);
   endtask

   task automatic read_check(input string tag);
      int exp;
      bus.load_mem = 1'b1;
      for (int idx = 0; idx < N; idx++) begin
         bus.addrC = AW'(idx);
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin
            check($sformatf("%s_sb_empty", tag), 0, 1);
         end else begin
            exp = exp_q.pop_front();
            check($sformatf("%s_C[%0d]", tag, idx), int'(bus.rdC), exp);
         end
      end
      bus.load_mem = 1'b0;
   endtask

   initial begin
      vecs[0] = '{0, 1, 1'b0, 1'b0, 1'b1, 0,     1'b0};
      vecs[1] = '{2, 3, 1'b1, 1'b0, 1'b1, 100,   1'b0};
      vecs[2] = '{4, 4, 1'b0, 1'b1, 1'b1, 0,     1'b0};
      vecs[3] = '{5, 5, 1'b0, 1'b0, 1'b1, 0,     1'b1};
      vecs[4] = '{5, 5, 1'b0, 1'b0, 1'b0, 0,     1'b1};
      vecs[5] = '{5, 6, 1'b1, 1'b0, 1'b1, 32256, 1'b0};
      vecs[6] = '{5, 6, 1'b1, 1'b0, 1'b0, 32255, 1'b1};

      reset = 1'b1;
      bus.load_mem = 1'b0; bus.wenA = 1'b0; bus.wenB = 1'b0; bus.wenC = 1'b0;
      bus.addrA = '0; bus.addrB = '0; bus.addrC = '0;
      bus.wdA = '0; bus.wdB = '0; bus.wdC = '0;
      bus.start = 1'b0; bus.acc_mode = 1'b0; bus.transB = 1'b0; bus.sat_en = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_ovf", int'(bus.ovf), 0);

      bus.load_mem = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.load_mem = 1'b0;
      check("start_with_load_mem_ignored", int'(bus.busy), 0);

      for (int v = 0; v < 7; v++) begin
         load(vecs[v]);
         push_expected(vecs[v]);
         run_pass(vecs[v], 0);
         read_check($sformatf("vec%0d", v));
      end

      load(vecs[0]);
      push_expected(vecs[0]);
      run_pass(vecs[0], 1);
      read_check("disturbed");
      push_expected(vecs[0]);
      run_pass(vecs[0], 0);
      read_check("rerun_a_intact");

      load(vecs[3]);
      run_pass(vecs[3], 2);
      push_expected(vecs[3]);
      run_pass(vecs[3], 0);
      read_check("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
